// File: rtl/fpu_addsub_arbiter_if.sv
// Request, issue and result signals shared between fpu_addsub_arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the requester/datapath side.
interface fpu_addsub_arbiter_if;
  logic        req_valid0, req_valid1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        req_sub0, req_sub1;
  logic        req_ready0, req_ready1;
  logic        issue_valid;
  logic [31:0] issue_a, issue_b;
  logic        issue_sub;
  logic [1:0]  issue_subnormal_status;
  logic [31:0] pipe_result;
  logic        res_valid0, res_valid1;
  logic [31:0] res_data;

  modport slave (
    input  req_valid0, req_valid1, req_a0, req_b0, req_a1, req_b1, req_sub0, req_sub1,
    input  pipe_result,
    output req_ready0, req_ready1,
    output issue_valid, issue_a, issue_b, issue_sub, issue_subnormal_status,
    output res_valid0, res_valid1, res_data
  );

  modport master (
    output req_valid0, req_valid1, req_a0, req_b0, req_a1, req_b1, req_sub0, req_sub1,
    output pipe_result,
    input  req_ready0, req_ready1,
    input  issue_valid, issue_a, issue_b, issue_sub, issue_subnormal_status,
    input  res_valid0, res_valid1, res_data
  );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Two-port round-robin arbiter in front of a fixed-latency FP add/sub datapath.
// Tracks in-flight issues with a {valid, port} tag pipe and returns each result to its issuer.
module fpu_addsub_arbiter #(
  parameter int LAT     = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_addsub_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  function automatic logic is_subnormal(input logic [31:0] x);
    return (x[30:23] == 8'd0) && (x[22:0] != 23'd0);
  endfunction

  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             last_grant_q, last_grant_d;
  logic             issue_valid_q, issue_valid_d;
  logic [31:0]      issue_a_q, issue_a_d, issue_b_q, issue_b_d;
  logic             issue_sub_q, issue_sub_d;
  logic [1:0]       issue_sn_q, issue_sn_d;
  logic             issue_port_q, issue_port_d;
  logic [LAT-1:0]   tag_valid_q, tag_valid_d, tag_port_q, tag_port_d;
  logic             res_valid0_q, res_valid0_d, res_valid1_q, res_valid1_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             elig0, elig1, grant0, grant1, accept;

  // Stage 0 takes the current issue; later stages shift toward the result capture point.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_d[gi] = issue_valid_q;
        assign tag_port_d[gi]  = issue_port_q;
      end else begin : g_body
        assign tag_valid_d[gi] = tag_valid_q[gi-1];
        assign tag_port_d[gi]  = tag_port_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    // A slot returned by this cycle's result strobe is already reusable.
    elig0  = bus.req_valid0 && ((cnt0_q < MAX_CNT) || res_valid0_q);
    elig1  = bus.req_valid1 && ((cnt1_q < MAX_CNT) || res_valid1_q);
    grant0 = rst_n && elig0 && (!elig1 || last_grant_q);
    grant1 = rst_n && elig1 && (!elig0 || !last_grant_q);
    accept = grant0 || grant1;

    last_grant_d  = accept ? grant1 : last_grant_q;
    issue_valid_d = accept;
    issue_port_d  = accept ? grant1 : issue_port_q;
    issue_a_d     = issue_a_q;
    issue_b_d     = issue_b_q;
    issue_sub_d   = issue_sub_q;
    issue_sn_d    = issue_sn_q;
    if (grant0) begin
      issue_a_d   = bus.req_a0;
      issue_b_d   = bus.req_b0;
      issue_sub_d = bus.req_sub0;
      issue_sn_d  = {is_subnormal(bus.req_a0), is_subnormal(bus.req_b0)};
    end else if (grant1) begin
      issue_a_d   = bus.req_a1;
      issue_b_d   = bus.req_b1;
      issue_sub_d = bus.req_sub1;
      issue_sn_d  = {is_subnormal(bus.req_a1), is_subnormal(bus.req_b1)};
    end

    res_valid0_d = tag_valid_q[LAT-1] && !tag_port_q[LAT-1];
    res_valid1_d = tag_valid_q[LAT-1] &&  tag_port_q[LAT-1];
    res_data_d   = tag_valid_q[LAT-1] ? bus.pipe_result : res_data_q;

    cnt0_d = cnt0_q + CNT_W'(grant0) - CNT_W'(res_valid0_q);
    cnt1_d = cnt1_q + CNT_W'(grant1) - CNT_W'(res_valid1_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      last_grant_q  <= 1'b1;
      issue_valid_q <= 1'b0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      issue_sub_q   <= 1'b0;
      issue_sn_q    <= '0;
      issue_port_q  <= 1'b0;
      tag_valid_q   <= '0;
      tag_port_q    <= '0;
      res_valid0_q  <= 1'b0;
      res_valid1_q  <= 1'b0;
      res_data_q    <= '0;
    end else begin
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      last_grant_q  <= last_grant_d;
      issue_valid_q <= issue_valid_d;
      issue_a_q     <= issue_a_d;
      issue_b_q     <= issue_b_d;
      issue_sub_q   <= issue_sub_d;
      issue_sn_q    <= issue_sn_d;
      issue_port_q  <= issue_port_d;
      tag_valid_q   <= tag_valid_d;
      tag_port_q    <= tag_port_d;
      res_valid0_q  <= res_valid0_d;
      res_valid1_q  <= res_valid1_d;
      res_data_q    <= res_data_d;
    end
  end

  assign bus.req_ready0             = grant0;
  assign bus.req_ready1             = grant1;
  assign bus.issue_valid            = issue_valid_q;
  assign bus.issue_a                = issue_a_q;
  assign bus.issue_b                = issue_b_q;
  assign bus.issue_sub              = issue_sub_q;
  assign bus.issue_subnormal_status = issue_sn_q;
  assign bus.res_valid0             = res_valid0_q;
  assign bus.res_valid1             = res_valid1_q;
  assign bus.res_data               = res_data_q;

endmodule
